xbar_demux_slave_resp: RTL and testbench

- Responder-side endpoint of the XBAR demux bus. It accepts core-side requests on the bus Slave signal set and drives a fixed-latency memory/peripheral port.
- It buffers responses in a small FIFO and honours response back-pressure (r_gnt). It also implements the busy, barrier, exec_stall and exec_cancel semantics.
- Sits between the demux output and a TCDM-like or register-file target.

---
 rtl/xbar_demux_slave_resp_if.sv | 39 +++
 rtl/xbar_demux_slave_resp.sv | 163 ++++++++++++++++
 tb/tb_xbar_demux_slave_resp.sv | 236 +++++++++++++++++++++++
 3 files changed

// File: rtl/xbar_demux_slave_resp_if.sv
// -----------------------------------------------------------------------------
// xbar_demux_slave_resp_if
// Core-side request/response bus of the XBAR demux responder endpoint.
//
// Signals (named from the responder's point of view):
//   req_i / add_i / we_i / wdata_i / be_i : request from the initiator
//   gnt_o                                 : request grant back to the initiator
//   r_gnt_i                               : initiator accepts the response
//   r_valid_o / r_rdata_o                 : response to the initiator
//
// Modports:
//   slave  : the responder endpoint (xbar_demux_slave_resp)
//   master : the initiator driving requests and consuming responses
// -----------------------------------------------------------------------------
interface xbar_demux_slave_resp_if #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int BE_WIDTH   = DATA_WIDTH / 8
);
    logic                  req_i;
    logic [ADDR_WIDTH-1:0] add_i;
    logic                  we_i;
    logic [DATA_WIDTH-1:0] wdata_i;
    logic [BE_WIDTH-1:0]   be_i;
    logic                  gnt_o;
    logic                  r_gnt_i;
    logic                  r_valid_o;
    logic [DATA_WIDTH-1:0] r_rdata_o;

    modport slave (
        input  req_i, add_i, we_i, wdata_i, be_i, r_gnt_i,
        output gnt_o, r_valid_o, r_rdata_o
    );

    modport master (
        output req_i, add_i, we_i, wdata_i, be_i, r_gnt_i,
        input  gnt_o, r_valid_o, r_rdata_o
    );
endinterface

// File: rtl/xbar_demux_slave_resp.sv
// -----------------------------------------------------------------------------
// xbar_demux_slave_resp
// Responder-side endpoint of the XBAR demux bus. Accepts requests from the
// core-side bus, drives a fixed-latency memory/peripheral port, buffers the
// responses in a small FIFO and returns them in order under r_gnt back-pressure.
//
// Ports:
//   clk, rst_n     : clock, asynchronous active-low reset
//   barrier_i      : no new grant while transactions are outstanding
//   exec_cancel_i  : block grant, flush every undelivered response
//   exec_stall_i   : block grant for this cycle only
//   bus            : request/response bus (slave modport)
//   busy_o         : one or more transactions outstanding
//   mem_req_o, mem_add_o, mem_we_o, mem_wdata_o, mem_be_o : memory request
//   mem_rdata_i    : memory read data, valid MEM_LATENCY cycles after mem_req_o
//
// Every transfer (read or write) yields exactly one response. The outstanding
// count covers both in-flight pipeline entries and FIFO occupancy, so a grant
// is only given when a FIFO slot is guaranteed for its response.
// -----------------------------------------------------------------------------
module xbar_demux_slave_resp #(
    parameter int ADDR_WIDTH  = 32,
    parameter int DATA_WIDTH  = 32,
    parameter int BE_WIDTH    = DATA_WIDTH / 8,
    parameter int MEM_LATENCY = 1,
    parameter int RESP_DEPTH  = 2
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  barrier_i,
    input  logic                  exec_cancel_i,
    input  logic                  exec_stall_i,
    xbar_demux_slave_resp_if.slave bus,
    output logic                  busy_o,
    output logic                  mem_req_o,
    output logic [ADDR_WIDTH-1:0] mem_add_o,
    output logic                  mem_we_o,
    output logic [DATA_WIDTH-1:0] mem_wdata_o,
    output logic [BE_WIDTH-1:0]   mem_be_o,
    input  logic [DATA_WIDTH-1:0] mem_rdata_i
);

    localparam int CW = $clog2(RESP_DEPTH + 1);
    localparam int PW = (RESP_DEPTH > 1) ? $clog2(RESP_DEPTH) : 1;
    localparam logic [CW-1:0] DEPTH_C  = CW'(RESP_DEPTH);
    localparam logic [PW-1:0] LAST_PTR = PW'(RESP_DEPTH - 1);

    // Outstanding transactions: in flight in the pipeline plus held in the FIFO.
    logic [CW-1:0] cnt_q, cnt_d;

    // In-flight tracking: stage k holds the transfer issued k+1 cycles ago.
    logic [MEM_LATENCY-1:0] pipe_vld_q;
    logic [MEM_LATENCY-1:0] pipe_we_q;

    // Response FIFO.
    logic [DATA_WIDTH-1:0] fifo_mem [RESP_DEPTH];
    logic [PW-1:0]         wr_ptr_q;
    logic [PW-1:0]         rd_ptr_q;
    logic [CW-1:0]         fifo_cnt_q;

    logic                  fifo_empty;
    logic                  transfer;
    logic                  push;
    logic                  pop;
    logic [DATA_WIDTH-1:0] push_data;

    assign fifo_empty = (fifo_cnt_q == '0);
    assign busy_o     = (cnt_q != '0);

    // Credit check uses the registered count only, so a pop this cycle cannot
    // reach gnt_o combinationally; the freed slot is visible next cycle.
    assign transfer = bus.req_i & ~exec_stall_i & ~exec_cancel_i
                    & ~(barrier_i & busy_o) & (cnt_q < DEPTH_C);

    assign bus.gnt_o   = transfer;
    assign mem_req_o   = transfer;
    assign mem_add_o   = bus.add_i;
    assign mem_we_o    = bus.we_i;
    assign mem_wdata_o = bus.wdata_i;
    assign mem_be_o    = bus.be_i;

    // The memory data is valid exactly while the tail stage is occupied.
    assign push      = pipe_vld_q[MEM_LATENCY-1];
    assign push_data = pipe_we_q[MEM_LATENCY-1] ? '0 : mem_rdata_i;
    assign pop       = ~fifo_empty & bus.r_gnt_i;

    assign bus.r_valid_o = ~fifo_empty;
    assign bus.r_rdata_o = fifo_empty ? '0 : fifo_mem[rd_ptr_q];

    always_comb begin
        // NOTE: default assignment first so no path leaves cnt_d unassigned,
        // which would otherwise infer a latch.
        cnt_d = cnt_q;
        if (transfer && !pop) begin
            cnt_d = cnt_q + CW'(1);
        end else if (!transfer && pop) begin
            cnt_d = cnt_q - CW'(1);
        end
    end

    // NOTE: all sequential state uses non-blocking assignments so every
    // register samples pre-edge values regardless of process ordering.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else if (exec_cancel_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pipe_vld_q <= '0;
            pipe_we_q  <= '0;
        end else if (exec_cancel_i) begin
            pipe_vld_q <= '0;
            pipe_we_q  <= '0;
        end else begin
            pipe_vld_q[0] <= transfer;
            pipe_we_q[0]  <= bus.we_i;
            for (int i = 1; i < MEM_LATENCY; i++) begin
                pipe_vld_q[i] <= pipe_vld_q[i-1];
                pipe_we_q[i]  <= pipe_we_q[i-1];
            end
        end
    end

    // Pointers wrap explicitly so non-power-of-2 depths work.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            fifo_cnt_q <= '0;
        end else if (exec_cancel_i) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            fifo_cnt_q <= '0;
        end else begin
            if (push) begin
                wr_ptr_q <= (wr_ptr_q == LAST_PTR) ? '0 : wr_ptr_q + PW'(1);
            end
            if (pop) begin
                rd_ptr_q <= (rd_ptr_q == LAST_PTR) ? '0 : rd_ptr_q + PW'(1);
            end
            if (push && !pop) begin
                fifo_cnt_q <= fifo_cnt_q + CW'(1);
            end else if (pop && !push) begin
                fifo_cnt_q <= fifo_cnt_q - CW'(1);
            end
        end
    end

    // NOTE: the data array has no reset; an entry is only observed after it
    // has been written, and r_rdata_o is forced to 0 while the FIFO is empty.
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_mem[wr_ptr_q] <= push_data;
        end
    end

endmodule

// File: tb/tb_xbar_demux_slave_resp.sv
// -----------------------------------------------------------------------------
// tb_xbar_demux_slave_resp
// Self-checking bench for xbar_demux_slave_resp. The reference model keeps the
// outstanding transactions in a queue, each stamped with the cycle its response
// becomes visible; the memory returns a fresh random word every cycle, so a
// response carries the word present MEM_LATENCY cycles after its request.
// -----------------------------------------------------------------------------
module tb_xbar_demux_slave_resp;

    localparam int AW    = 32;
    localparam int DW    = 32;
    localparam int BW    = 4;
    localparam int LAT   = 2;
    localparam int DEPTH = 3;
    localparam int MAXC  = 4096;

    logic          clk;
    logic          rst_n;
    logic          barrier_i;
    logic          exec_cancel_i;
    logic          exec_stall_i;
    logic          busy_o;
    logic          mem_req_o;
    logic [AW-1:0] mem_add_o;
    logic          mem_we_o;
    logic [DW-1:0] mem_wdata_o;
    logic [BW-1:0] mem_be_o;
    logic [DW-1:0] mem_rdata_i;

    xbar_demux_slave_resp_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .BE_WIDTH(BW)) bus ();

    xbar_demux_slave_resp #(
        .ADDR_WIDTH (AW),
        .DATA_WIDTH (DW),
        .BE_WIDTH   (BW),
        .MEM_LATENCY(LAT),
        .RESP_DEPTH (DEPTH)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .barrier_i    (barrier_i),
        .exec_cancel_i(exec_cancel_i),
        .exec_stall_i (exec_stall_i),
        .bus          (bus),
        .busy_o       (busy_o),
        .mem_req_o    (mem_req_o),
        .mem_add_o    (mem_add_o),
        .mem_we_o     (mem_we_o),
        .mem_wdata_o  (mem_wdata_o),
        .mem_be_o     (mem_be_o),
        .mem_rdata_i  (mem_rdata_i)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int            ready;
        logic [DW-1:0] data;
    } resp_t;

    resp_t         q[$];
    logic [DW-1:0] rdata_tab [MAXC];
    int            cyc;
    int            n_checks;
    int            n_fail;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s cyc=%0d got=%h exp=%h", tag, cyc, got, exp);
        end
    endtask

    // One bus cycle: drive at posedge+1, compare at negedge, advance the model
    // at the posedge.
    task automatic step(input bit req, input bit we, input logic [AW-1:0] add,
                        input logic [DW-1:0] wdata, input logic [BW-1:0] be,
                        input bit rg, input bit bar, input bit stl, input bit can);
        bit            exp_gnt;
        bit            exp_rv;
        logic [DW-1:0] exp_rd;
        int            n;
        resp_t         r;
        bus.req_i     = req;
        bus.we_i      = we;
        bus.add_i     = add;
        bus.wdata_i   = wdata;
        bus.be_i      = be;
        bus.r_gnt_i   = rg;
        barrier_i     = bar;
        exec_stall_i  = stl;
        exec_cancel_i = can;
        mem_rdata_i   = rdata_tab[cyc];
        n       = q.size();
        exp_rv  = (n > 0) && (q[0].ready <= cyc);
        exp_rd  = exp_rv ? q[0].data : '0;
        exp_gnt = req && !stl && !can && !(bar && n != 0) && (n < DEPTH);
        @(negedge clk);
        check("gnt", 64'(bus.gnt_o), 64'(exp_gnt));
        check("mem_req", 64'(mem_req_o), 64'(exp_gnt));
        check("r_valid", 64'(bus.r_valid_o), 64'(exp_rv));
        check("r_rdata", 64'(bus.r_rdata_o), 64'(exp_rd));
        check("busy", 64'(busy_o), 64'(n != 0));
        if (exp_gnt) begin
            check("mem_add", 64'(mem_add_o), 64'(add));
            check("mem_we", 64'(mem_we_o), 64'(we));
            check("mem_wdata", 64'(mem_wdata_o), 64'(wdata));
            check("mem_be", 64'(mem_be_o), 64'(be));
        end
        @(posedge clk);
        if (can) begin
            q.delete();
        end else begin
            if (exp_rv && rg) begin
                void'(q.pop_front());
            end
            if (exp_gnt) begin
                r.ready = cyc + LAT + 1;
                r.data  = we ? '0 : rdata_tab[cyc + LAT];
                q.push_back(r);
            end
        end
        cyc++;
        #1;
    endtask

    task automatic idle(input bit rg, input int n);
        for (int i = 0; i < n; i++) begin
            step(1'b0, 1'b0, '0, '0, '0, rg, 1'b0, 1'b0, 1'b0);
        end
    endtask

    task automatic rd(input logic [AW-1:0] add, input bit rg);
        step(1'b1, 1'b0, add, '0, 4'hF, rg, 1'b0, 1'b0, 1'b0);
    endtask

    // Asserts reset mid-cycle, away from any clock edge, and checks the
    // outputs clear before the next edge.
    task automatic async_reset_mid();
        #2;
        check("pre_rst_rvalid", 64'(bus.r_valid_o), 64'(q.size() > 0 && q[0].ready <= cyc));
        rst_n = 1'b0;
        #1;
        check("rst_rvalid", 64'(bus.r_valid_o), 64'(0));
        check("rst_busy", 64'(busy_o), 64'(0));
        check("rst_rdata", 64'(bus.r_rdata_o), 64'(0));
        q.delete();
        @(posedge clk);
        cyc++;
        #2;
        rst_n = 1'b1;
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        cyc      = 0;
        for (int i = 0; i < MAXC; i++) begin
            rdata_tab[i] = $urandom;
        end
        rst_n         = 1'b0;
        bus.req_i     = 1'b0;
        bus.we_i      = 1'b0;
        bus.add_i     = '0;
        bus.wdata_i   = '0;
        bus.be_i      = '0;
        bus.r_gnt_i   = 1'b0;
        barrier_i     = 1'b0;
        exec_stall_i  = 1'b0;
        exec_cancel_i = 1'b0;
        mem_rdata_i   = '0;
        #12;
        check("reset_gnt", 64'(bus.gnt_o), 64'(0));
        check("reset_mem_req", 64'(mem_req_o), 64'(0));
        check("reset_rvalid", 64'(bus.r_valid_o), 64'(0));
        check("reset_rdata", 64'(bus.r_rdata_o), 64'(0));
        check("reset_busy", 64'(busy_o), 64'(0));
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Single read, response taken as soon as it appears.
        rd(32'h100, 1'b1);
        idle(1'b1, 5);

        // Back-pressure: credits run out, then drain in order.
        for (int i = 0; i < 6; i++) rd(32'h200 + 32'(i * 4), 1'b0);
        for (int i = 0; i < 4; i++) rd(32'h300, 1'b1);
        idle(1'b1, 6);

        // Write response carries zero data.
        step(1'b1, 1'b1, 32'h400, 32'hCAFEF00D, 4'hF, 1'b1, 1'b0, 1'b0, 1'b0);
        idle(1'b1, 5);

        // Barrier: blocked while busy, transparent once idle.
        rd(32'h500, 1'b0);
        for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 32'h504, '0, 4'h3, 1'b0, 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 6; i++) step(1'b1, 1'b0, 32'h508, '0, 4'h3, 1'b1, 1'b1, 1'b0, 1'b0);
        idle(1'b1, 5);

        // Stall blocks a single cycle only.
        step(1'b1, 1'b0, 32'h600, '0, 4'hF, 1'b1, 1'b0, 1'b1, 1'b0);
        rd(32'h600, 1'b1);
        idle(1'b1, 5);

        // Cancel with two reads outstanding, then immediate new request.
        rd(32'h700, 1'b0);
        rd(32'h704, 1'b0);
        idle(1'b0, 3);
        step(1'b1, 1'b0, 32'h708, '0, 4'hF, 1'b0, 1'b0, 1'b0, 1'b1);
        rd(32'h70C, 1'b1);
        idle(1'b1, 5);

        // Reset mid-operation with a response parked in the FIFO.
        rd(32'h800, 1'b0);
        idle(1'b0, 3);
        async_reset_mid();
        rd(32'h804, 1'b1);
        idle(1'b1, 5);

        // Randomised traffic.
        for (int i = 0; i < 2000; i++) begin
            step($urandom_range(0, 3) != 0, $urandom_range(0, 2) == 0, $urandom,
                 $urandom, 4'($urandom), $urandom_range(0, 2) != 0,
                 $urandom_range(0, 7) == 0, $urandom_range(0, 9) == 0,
                 $urandom_range(0, 39) == 0);
        end
        idle(1'b1, 8);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
